// File: rtl/ram_stream_reader_if.sv
// Command, RAM read port and output stream bundle for ram_stream_reader.
// The master modport is the reader's view; slave is the command source, RAM and sink side.
interface ram_stream_reader_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 16
);
  logic                  s_cmd_valid;
  logic                  s_cmd_ready;
  logic [ADDR_WIDTH-1:0] s_cmd_addr;
  logic [LEN_WIDTH-1:0]  s_cmd_len;

  logic                  ram_ena;
  logic                  ram_ren;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_dout;

  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic [KEEP_WIDTH-1:0] m_axis_tkeep;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport master (
    input  s_cmd_valid, s_cmd_addr, s_cmd_len, ram_dout, m_axis_tready,
    output s_cmd_ready, ram_ena, ram_ren, ram_raddr,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output s_cmd_valid, s_cmd_addr, s_cmd_len, ram_dout, m_axis_tready,
    input  s_cmd_ready, ram_ena, ram_ren, ram_raddr,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Reads a {addr, byte length} span from a fixed-latency RAM and streams it out as AXI4-Stream.
// Reads are issued only while FIFO space covers everything in flight, so backpressure never drops data.
//
//   state  | meaning
//   S_IDLE | waiting for a command, s_cmd_ready high
//   S_READ | issuing word reads as credit allows
//   S_WAIT | all reads issued, draining until the tlast beat handshakes
module ram_stream_reader #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 128,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int LEN_WIDTH    = 16,
  parameter int READ_LATENCY = 3,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                clk,
  input  logic                rst,
  ram_stream_reader_if.master bus,
  output logic                busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = DATA_WIDTH + KEEP_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] raddr;
  logic [LEN_WIDTH:0]    words_left;
  logic [KEEP_WIDTH-1:0] keep_last;
  logic [LEN_WIDTH:0]    cmd_words;
  logic [LEN_WIDTH-1:0]  cmd_rem;
  logic [KEEP_WIDTH-1:0] cmd_keep;
  logic                  cmd_fire, ren, push, pop, last_word, credit_ok;

  logic [CW-1:0]         fifo_count, inflight;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [FW-1:0]         fifo_mem [FIFO_DEPTH];
  logic [FW-1:0]         fifo_head;

  logic                  pipe_vld  [READ_LATENCY];
  logic                  pipe_last [READ_LATENCY];
  logic [KEEP_WIDTH-1:0] pipe_keep [READ_LATENCY];

  assign bus.s_cmd_ready = (state == S_IDLE) && !rst;
  assign cmd_fire        = bus.s_cmd_valid && bus.s_cmd_ready;

  assign cmd_words = ({1'b0, bus.s_cmd_len} + (LEN_WIDTH+1)'(KEEP_WIDTH - 1))
                     / (LEN_WIDTH+1)'(KEEP_WIDTH);
  assign cmd_rem   = bus.s_cmd_len % LEN_WIDTH'(KEEP_WIDTH);

  always_comb begin
    cmd_keep = '1;
    if (cmd_rem != '0) begin
      for (int i = 0; i < KEEP_WIDTH; i++)
        cmd_keep[i] = LEN_WIDTH'(i) < cmd_rem;
    end
  end

  assign last_word = words_left == (LEN_WIDTH+1)'(1);
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ren       = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: if (cmd_fire) state_nxt = S_READ;
      S_READ: begin
        busy = 1'b1;
        // words_left is only zero here for a zero-length command
        if (words_left == '0) state_nxt = S_IDLE;
        else begin
          ren = credit_ok;
          if (ren && last_word) state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (pop && bus.m_axis_tlast) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raddr      <= '0;
      words_left <= '0;
      keep_last  <= '0;
    end else if (cmd_fire) begin
      raddr      <= bus.s_cmd_addr;
      words_left <= cmd_words;
      keep_last  <= cmd_keep;
    end else if (ren) begin
      raddr      <= raddr + ADDR_WIDTH'(1);
      words_left <= words_left - (LEN_WIDTH+1)'(1);
    end
  end

  assign bus.ram_ena   = ren;
  assign bus.ram_ren   = ren;
  assign bus.ram_raddr = raddr;

  // Sidecar pipeline matching the RAM latency; its exit stage qualifies ram_dout
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_last[i] <= 1'b0;
        pipe_keep[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= ren;
      pipe_last[0] <= last_word;
      pipe_keep[0] <= last_word ? keep_last : '1;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
        pipe_keep[i] <= pipe_keep[i-1];
      end
    end
  end

  assign push = pipe_vld[READ_LATENCY-1];
  assign pop  = bus.m_axis_tvalid && bus.m_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({ren, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {bus.ram_dout, pipe_keep[READ_LATENCY-1], pipe_last[READ_LATENCY-1]};
  end

  assign fifo_head         = fifo_mem[rd_ptr];
  assign bus.m_axis_tvalid = fifo_count != '0;
  assign bus.m_axis_tdata  = bus.m_axis_tvalid ? fifo_head[FW-1 -: DATA_WIDTH] : '0;
  assign bus.m_axis_tkeep  = bus.m_axis_tvalid ? fifo_head[KEEP_WIDTH:1] : '0;
  assign bus.m_axis_tlast  = bus.m_axis_tvalid && fifo_head[0];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && fifo_count == CW'(FIFO_DEPTH)));
endmodule
